// File: rtl/taxi_eth_phy_10g_pkg.sv
// Shared 10G PHY definitions: gearbox state encoding and the 64b/66b gearbox
// sequence constants.
package taxi_eth_phy_10g_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    ERR
  } gbx_state_t;

  localparam int GBX_SEQ_LEN = 33;
  localparam int BLOCK_BITS  = 66;
  localparam int GBX_PRIME   = 64;

endpackage

// File: rtl/taxi_eth_phy_10g_tx_gbx_seq.sv
// Free-running 33-cycle gearbox sequencer with registered stall/sync requests.
// Also suitable for driving the RX slip logic.
module taxi_eth_phy_10g_tx_gbx_seq
  import taxi_eth_phy_10g_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] seq_o,
  output logic       req_sync_o,
  output logic       req_stall_o
);

  logic [5:0] seq_q, seq_d;
  logic       req_q, req_d;

  always_comb begin
    seq_d = (seq_q == 6'(GBX_SEQ_LEN - 1)) ? 6'd0 : seq_q + 6'd1;
    // registered, so it is high while seq_q sits at the second-to-last slot
    req_d = (seq_d == 6'(GBX_SEQ_LEN - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
      req_q <= 1'b0;
    end else begin
      seq_q <= seq_d;
      req_q <= req_d;
    end
  end

  assign seq_o       = seq_q;
  assign req_sync_o  = req_q;
  assign req_stall_o = req_q;

endmodule

// File: rtl/taxi_eth_phy_10g_tx_gbx.sv
// 64b/66b TX gearbox: packs 2-bit headers and 32-bit words into a continuous
// 32-bit SERDES stream, pacing upstream with one stall per 33 cycles.
module taxi_eth_phy_10g_tx_gbx
  import taxi_eth_phy_10g_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int HDR_W  = 2,
  parameter int BUF_W  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_data_valid,
  input  logic [HDR_W-1:0]  in_hdr,
  input  logic              in_hdr_valid,
  input  logic              in_gbx_sync,
  output logic              tx_gbx_req_sync,
  output logic              tx_gbx_req_stall,
  output logic [DATA_W-1:0] serdes_tx_data,
  output logic              serdes_tx_data_valid,
  output logic              stat_gbx_err,
  output logic              stat_gbx_underflow
);

  localparam int APP_W = DATA_W + HDR_W;
  localparam int CNT_W = $clog2(BUF_W + APP_W + 1);

  if (DATA_W != 32 || HDR_W + 2 * DATA_W != BLOCK_BITS) begin : g_bad_width
    $error("taxi_eth_phy_10g_tx_gbx: only DATA_W=32 with HDR_W=2 is supported");
  end

  logic [5:0]        seq;
  logic              req_sync;

  gbx_state_t        state_q, state_d;
  logic [BUF_W-1:0]  sbuf_q, sbuf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q, vld_d, err_q, err_d, uf_q, uf_d;

  logic [APP_W-1:0]  app;
  logic [CNT_W-1:0]  add, cnt_app, pos, cnt_next;
  logic              emit, overflow, underflow, misalign, load;

  taxi_eth_phy_10g_tx_gbx_seq u_seq (
    .clk         (clk),
    .rst         (rst),
    .seq_o       (seq),
    .req_sync_o  (req_sync),
    .req_stall_o (tx_gbx_req_stall)
  );

  always_comb begin
    app = '0;
    add = '0;
    if (in_data_valid) begin
      if (in_hdr_valid) begin
        app = {in_data, in_hdr};
        add = CNT_W'(APP_W);
      end else begin
        app = APP_W'(in_data);
        add = CNT_W'(DATA_W);
      end
    end
  end

  // The FILL->RUN cycle already emits, so the first header bit is on the wire
  // two cycles after the first header word is accepted.
  assign cnt_app   = cnt_q + add;
  assign emit      = ((state_q == RUN) && (cnt_q >= CNT_W'(DATA_W))) ||
                     ((state_q == FILL) && (cnt_app >= CNT_W'(GBX_PRIME)));
  assign pos       = emit ? cnt_q - CNT_W'(DATA_W) : cnt_q;
  assign cnt_next  = pos + add;
  assign overflow  = cnt_next > CNT_W'(BUF_W);
  assign underflow = (state_q == RUN) && (cnt_q < CNT_W'(DATA_W));
  assign misalign  = in_data_valid &&
                     ((seq == 6'(GBX_SEQ_LEN - 1)) || (pend_q && !(in_hdr_valid && in_gbx_sync)));
  assign load      = in_data_valid && in_hdr_valid && in_gbx_sync && (seq == 6'd0);
  assign pend_d    = req_sync ? 1'b1 : (in_data_valid ? 1'b0 : pend_q);

  always_comb begin
    state_d = state_q;
    sbuf_d  = sbuf_q;
    cnt_d   = cnt_q;
    data_d  = '0;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    uf_d    = 1'b0;
    case (state_q)
      IDLE: begin
        sbuf_d = '0;
        cnt_d  = '0;
        if (load) begin
          sbuf_d  = BUF_W'(app);
          cnt_d   = CNT_W'(APP_W);
          state_d = FILL;
        end
      end
      FILL, RUN: begin
        if (misalign || overflow) begin
          err_d   = 1'b1;
          state_d = ERR;
          sbuf_d  = '0;
          cnt_d   = '0;
        end else if (underflow) begin
          uf_d    = 1'b1;
          state_d = ERR;
          sbuf_d  = '0;
          cnt_d   = '0;
        end else begin
          sbuf_d = (emit ? (sbuf_q >> DATA_W) : sbuf_q) | (BUF_W'(app) << pos);
          cnt_d  = cnt_next;
          if (emit) begin
            data_d  = sbuf_q[DATA_W-1:0];
            vld_d   = 1'b1;
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sbuf_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sbuf_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sbuf_q  <= sbuf_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      uf_q    <= uf_d;
    end
  end

  assign tx_gbx_req_sync      = req_sync;
  assign serdes_tx_data       = data_q;
  assign serdes_tx_data_valid = vld_q;
  assign stat_gbx_err         = err_q;
  assign stat_gbx_underflow   = uf_q;

endmodule

// File: doc/taxi_eth_phy_10g_tx_gbx.md
# taxi_eth_phy_10g_tx_gbx

64b/66b transmit gearbox that sits directly downstream of the 10G MAC/PHY TX path. It consumes the 32-bit scrambled data and 2-bit sync header stream, where the header accompanies every other word. It emits a continuous 32-bit SERDES word stream for transceivers with no internal gearbox. It paces the upstream with a one-in-33 stall request and block-alignment requests.

## Interface
Parameters:
- DATA_W, 32, data width; only 32 is supported, and elaboration fails for any other value.
- HDR_W, 2, sync header width.
- BUF_W, 128, bit-buffer depth.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- in_data  in  32  encoded data word; bit 0 is transmitted first.
- in_data_valid  in  1  in_data is valid.
- in_hdr  in  2  sync header; sampled only with in_hdr_valid.
- in_hdr_valid  in  1  current word is the first word of a block; in_hdr is valid.
- in_gbx_sync  in  1  upstream acknowledgement that the current word starts a block aligned to tx_gbx_req_sync.
- tx_gbx_req_sync  out  1  first valid word after this cycle must start a block.
- tx_gbx_req_stall  out  1  upstream must hold in_data_valid low in the next cycle.
- serdes_tx_data  out  32  gearboxed output word.
- serdes_tx_data_valid  out  1  output word valid; high only in RUN.
- stat_gbx_err  out  1  one-cycle pulse on overflow or misalignment.
- stat_gbx_underflow  out  1  one-cycle pulse on buffer starvation in RUN.

## Operation
- seq counter, 6 bits: increments every cycle and wraps from 32 to 0. It is free-running and independent of state.
- tx_gbx_req_stall and tx_gbx_req_sync are registered. Both are high exactly in the cycle where seq==31.
- Per block, the bit order is: in_hdr[1:0], then word0[31:0], then word1[31:0]. Total 66 bits.
- Appending:
  - A header word appends 34 bits.
  - A non-header valid word appends 32 bits.
  - Bits are appended at position cnt after the output shift.
- Output: when the state is RUN and cnt>=32, serdes_tx_data = buf[31:0] and the buffer shifts right by 32.
- Count arithmetic: cnt_next = cnt − (out?32:0) + added. cnt is 8 bits wide and saturates to no value, because overflow is checked first.
- State machine:
  - IDLE: buffer cleared, cnt=0. Waits for a valid word with in_hdr_valid && in_gbx_sync in the cycle after seq==32, then loads it and goes to FILL.
  - FILL: accumulates without output. Goes to RUN when cnt>=64.
  - RUN: outputs one word per cycle.
  - ERR: one cycle, pulses the status flag, then goes to IDLE.
- Errors, all of which go to ERR:
  - cnt_next>BUF_W raises stat_gbx_err.
  - A valid word in the cycle where seq==32 raises stat_gbx_err.
  - The first valid word after a tx_gbx_req_sync without in_hdr_valid && in_gbx_sync raises stat_gbx_err.
  - In RUN, cnt<32 at output time raises stat_gbx_underflow.
- Simultaneous events: overflow and underflow in the same cycle are impossible. A misalignment takes priority over an overflow; only stat_gbx_err pulses.

## Timing
- Reset values: seq=0, state IDLE, cnt=0, buffer 0, and every output 0.
- In steady state, 16 blocks (1056 bits) enter over 32 valid cycles and 1056 bits leave over 33 cycles.
- Latency: the first header word arrives in cycle T; the second word in T+1 reaches cnt=66. RUN begins at T+2. The first header bit appears on serdes_tx_data[0] at T+2.
- serdes_tx_data is registered. It holds 0 while serdes_tx_data_valid is low.
- Reset asserted mid-RUN: on the next clock, all state returns to reset values. There is no flush.
- in_gbx_sync outside a req_sync window is ignored.

## Structure
- Shared package taxi_eth_phy_10g_pkg holds:
  - the gearbox state enum (IDLE, FILL, RUN, ERR);
  - the constants GBX_SEQ_LEN=33, BLOCK_BITS=66 and GBX_PRIME=64.
- Sub-module taxi_eth_phy_10g_tx_gbx_seq: the seq counter plus registered req_sync/req_stall generation. It is reusable for the RX slip logic.

## Test plan
- Reset release, then compliant upstream sending 64 idle blocks (hdr=2'b10, data 0x1E): serdes_tx_data_valid rises 2 cycles after the first header. The output reproduces the 66-bit serial stream bit-exactly. No status pulses occur.
- Compliant stream over 10 gearbox periods: tx_gbx_req_stall is high exactly once per 33 cycles at seq==31. cnt stays within [32,128].
- Upstream drives a valid word at seq==32: stat_gbx_err pulses once. The state returns to IDLE. Output resumes after the next aligned header.
- After req_sync, the first valid word lacks in_hdr_valid: stat_gbx_err pulses. serdes_tx_data_valid drops within 2 cycles.
- Upstream drops in_data_valid for 3 consecutive non-stall cycles in RUN: stat_gbx_underflow pulses. The state returns to IDLE.
- rst asserted mid-RUN for one cycle: all outputs are 0 the next cycle and seq restarts at 0.
